// File: rtl/mapa_store.sv
// Block-map cell store: a COLS x ROWS grid of 2-bit cell types. The game logic writes cells,
// the renderer reads palette colours with one cycle of latency, and a sweep clears the grid.
module mapa_store #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int BLOCK_BITS    = 4,
  parameter int BLOCK_SIZE    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mapa_read,
  input  logic [9:0] mapa_x,
  input  logic [9:0] mapa_y,
  output logic [1:0] mapa_R,
  output logic [1:0] mapa_G,
  output logic [1:0] mapa_B,
  input  logic       wr_en,
  input  logic [9:0] wr_x,
  input  logic [9:0] wr_y,
  input  logic [1:0] wr_tipo,
  output logic       wr_ready,
  input  logic       clear_req,
  output logic       busy
);

  localparam int COLS   = SCREEN_WIDTH / BLOCK_SIZE;
  localparam int ROWS   = SCREEN_HEIGHT / BLOCK_SIZE;
  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = $clog2(CELLS);
  localparam int LIN_W  = 24;

  localparam logic [9:0]        COLS_V  = 10'(COLS);
  localparam logic [LIN_W-1:0]  CELLS_L = LIN_W'(CELLS);
  localparam logic [ADDR_W-1:0] SC_LAST = ADDR_W'(CELLS - 1);

  if ((1 << BLOCK_BITS) != BLOCK_SIZE) begin : g_block_check
    $error("BLOCK_SIZE must equal 2**BLOCK_BITS");
  end

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] sc;

  logic [1:0]        mem [CELLS];
  logic [1:0]        rd_tipo;
  logic              rd_ok;

  logic [LIN_W-1:0]  rd_lin;
  logic [LIN_W-1:0]  wr_lin;
  logic              rd_hit;
  logic              wr_hit;
  logic              wr_go;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [1:0]        mem_wdata;

  // Linear addresses are formed at full width; with x already below COLS, lin < CELLS
  // is exactly the y < ROWS test, so out-of-range coordinates can never alias a cell.
  assign rd_lin = LIN_W'(mapa_y) * LIN_W'(COLS) + LIN_W'(mapa_x);
  assign wr_lin = LIN_W'(wr_y) * LIN_W'(COLS) + LIN_W'(wr_x);

  assign rd_hit = mapa_read && (mapa_x < COLS_V) && (rd_lin < CELLS_L) && (state == IDLE);
  assign wr_hit = (wr_x < COLS_V) && (wr_lin < CELLS_L);

  assign busy     = (state == CLEAR);
  assign wr_ready = (state == IDLE);
  assign wr_go    = wr_en && wr_ready && !clear_req && wr_hit;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = sc;
    mem_wdata = '0;
    if (state == CLEAR) begin
      mem_we = 1'b1;
    end else if (wr_go) begin
      mem_we    = 1'b1;
      mem_waddr = wr_lin[ADDR_W-1:0];
      mem_wdata = wr_tipo;
    end
  end

  // Plain 1W/1R synchronous RAM; the read sees the pre-write contents on a shared edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    rd_tipo <= mem[rd_lin[ADDR_W-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      sc    <= '0;
      rd_ok <= 1'b0;
    end else begin
      rd_ok <= rd_hit;
      case (state)
        CLEAR: begin
          if (sc == SC_LAST) begin
            state <= IDLE;
            sc    <= '0;
          end else begin
            sc <= sc + ADDR_W'(1);
          end
        end
        IDLE: begin
          if (clear_req) begin
            state <= CLEAR;
            sc    <= '0;
          end
        end
        default: begin
          state <= CLEAR;
          sc    <= '0;
        end
      endcase
    end
  end

  // Palette decode sits after the RAM output register so the storage stays a plain RAM;
  // rd_ok forces black for blanking, out-of-range and in-sweep reads.
  always_comb begin
    mapa_R = '0;
    mapa_G = '0;
    mapa_B = '0;
    if (rd_ok) begin
      case (rd_tipo)
        2'd1: begin mapa_R = 2'b01; mapa_G = 2'b01; mapa_B = 2'b11; end
        2'd2: begin mapa_R = 2'b00; mapa_G = 2'b11; mapa_B = 2'b00; end
        2'd3: begin mapa_R = 2'b11; mapa_G = 2'b11; mapa_B = 2'b11; end
        default: begin mapa_R = 2'b00; mapa_G = 2'b00; mapa_B = 2'b00; end
      endcase
    end
  end

endmodule

// File: tb/tb_mapa_store.sv
// Directed bench for mapa_store: post-reset sweep, table-driven write/read vectors,
// clear-request priority and a reset that aborts a sweep half way through.
module tb_mapa_store;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mapa_read;
  logic [9:0] mapa_x, mapa_y;
  logic [1:0] mapa_R, mapa_G, mapa_B;
  logic       wr_en;
  logic [9:0] wr_x, wr_y;
  logic [1:0] wr_tipo;
  logic       wr_ready;
  logic       clear_req;
  logic       busy;
  logic [5:0] rgb;

  int tests = 0;
  int fails = 0;

  localparam logic [5:0] BLACK = 6'b00_00_00;
  localparam logic [5:0] T1    = 6'b01_01_11;
  localparam logic [5:0] T2    = 6'b00_11_00;
  localparam logic [5:0] T3    = 6'b11_11_11;

  mapa_store #(
    .SCREEN_WIDTH (640),
    .SCREEN_HEIGHT(480),
    .BLOCK_BITS   (4),
    .BLOCK_SIZE   (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mapa_read(mapa_read),
    .mapa_x   (mapa_x),
    .mapa_y   (mapa_y),
    .mapa_R   (mapa_R),
    .mapa_G   (mapa_G),
    .mapa_B   (mapa_B),
    .wr_en    (wr_en),
    .wr_x     (wr_x),
    .wr_y     (wr_y),
    .wr_tipo  (wr_tipo),
    .wr_ready (wr_ready),
    .clear_req(clear_req),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  assign rgb = {mapa_R, mapa_G, mapa_B};

  typedef struct {
    logic       we;
    logic [9:0] wx, wy;
    logic [1:0] wt;
    logic       rd;
    logic [9:0] rx, ry;
    logic [5:0] exp;
  } vec_t;

  vec_t v[14];

  function automatic vec_t mk(input logic we, input int wx, input int wy, input int wt,
                              input logic rd, input int rx, input int ry, input logic [5:0] exp);
    vec_t r;
    r.we = we; r.wx = 10'(wx); r.wy = 10'(wy); r.wt = 2'(wt);
    r.rd = rd; r.rx = 10'(rx); r.ry = 10'(ry); r.exp = exp;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic rd_check(input string nm, input int x, input int y, input logic [5:0] exp);
    wr_en = 1'b0; clear_req = 1'b0;
    mapa_read = 1'b1; mapa_x = 10'(x); mapa_y = 10'(y);
    tick();
    check(nm, 32'(rgb), 32'(exp));
  endtask

  // Runs exactly 1200 edges expecting busy before each and black after each, holding
  // clear_req and a write high for the first 'hold' edges, then expects IDLE.
  task automatic sweep(input string nm, input int hold);
    int bad_busy = 0;
    int bad_rgb  = 0;
    mapa_read = 1'b1; mapa_x = '0; mapa_y = '0;
    wr_x = 10'd1; wr_y = 10'd1; wr_tipo = 2'd3;
    for (int i = 0; i < 1200; i++) begin
      clear_req = (i < hold);
      wr_en     = (i < hold);
      if (busy !== 1'b1) bad_busy++;
      tick();
      if (rgb !== BLACK) bad_rgb++;
    end
    clear_req = 1'b0; wr_en = 1'b0;
    check({nm, "_busy_edges"}, 32'(bad_busy), 32'd0);
    check({nm, "_black_edges"}, 32'(bad_rgb), 32'd0);
    check({nm, "_busy_after"}, 32'(busy), 32'd0);
    check({nm, "_ready_after"}, 32'(wr_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b1;
    mapa_read = 1'b1; mapa_x = '0; mapa_y = '0;
    wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_tipo = '0;
    clear_req = 1'b0;
    #2 rst_n = 1'b0;

    v[0]  = mk(1'b1, 39, 29, 1, 1'b1, 39, 29, BLACK);
    v[1]  = mk(1'b0,  0,  0, 0, 1'b1, 39, 29, T1);
    v[2]  = mk(1'b1,  0,  1, 2, 1'b0,  0,  0, BLACK);
    v[3]  = mk(1'b1, 40,  0, 3, 1'b1,  0,  1, T2);
    v[4]  = mk(1'b0,  0,  0, 0, 1'b1,  0,  1, T2);
    v[5]  = mk(1'b0,  0,  0, 0, 1'b1, 40,  0, BLACK);
    v[6]  = mk(1'b1,  0, 52, 3, 1'b1, 1023, 1023, BLACK);
    v[7]  = mk(1'b0,  0,  0, 0, 1'b1, 32,  0, BLACK);
    v[8]  = mk(1'b1,  5,  5, 2, 1'b1,  5,  5, BLACK);
    v[9]  = mk(1'b0,  0,  0, 0, 1'b1,  5,  5, T2);
    v[10] = mk(1'b1,  0,  0, 3, 1'b0,  5,  5, BLACK);
    v[11] = mk(1'b0,  0,  0, 0, 1'b1,  0,  0, T3);
    v[12] = mk(1'b0,  0,  0, 0, 1'b1, 39, 29, T1);
    v[13] = mk(1'b0,  0,  0, 0, 1'b1, 39, 30, BLACK);

    // Reset held across edges
    @(negedge clk);
    tick();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ready", 32'(wr_ready), 32'd0);
    check("rst_rgb", 32'(rgb), 32'(BLACK));
    rst_n = 1'b1;

    sweep("init", 0);
    rd_check("idle_read00", 0, 0, BLACK);

    foreach (v[i]) begin
      wr_en = v[i].we; wr_x = v[i].wx; wr_y = v[i].wy; wr_tipo = v[i].wt;
      mapa_read = v[i].rd; mapa_x = v[i].rx; mapa_y = v[i].ry;
      clear_req = 1'b0;
      tick();
      check($sformatf("vec%0d", i), 32'(rgb), 32'(v[i].exp));
    end
    wr_en = 1'b0;
    check("vec_ready", 32'(wr_ready), 32'd1);

    // clear_req and a write on the same IDLE edge: clear wins
    wr_en = 1'b1; wr_x = 10'd1; wr_y = 10'd1; wr_tipo = 2'd3;
    clear_req = 1'b1;
    mapa_read = 1'b1; mapa_x = '0; mapa_y = '0;
    tick();
    check("clr_busy", 32'(busy), 32'd1);
    check("clr_ready", 32'(wr_ready), 32'd0);
    check("clr_edge_read", 32'(rgb), 32'(T3));
    sweep("clr", 5);
    rd_check("clr_cell11", 1, 1, BLACK);
    rd_check("clr_cell00", 0, 0, BLACK);
    rd_check("clr_cell3929", 39, 29, BLACK);
    rd_check("clr_cell55", 5, 5, BLACK);
    rd_check("clr_cell01", 0, 1, BLACK);

    // Reset in the middle of a sweep
    mapa_read = 1'b0;
    wr_en = 1'b1; wr_x = 10'd39; wr_y = 10'd29; wr_tipo = 2'd1;
    tick();
    wr_x = 10'd2; wr_y = 10'd2; wr_tipo = 2'd3;
    tick();
    rd_check("pre_cell22", 2, 2, T3);
    rd_check("pre_cell3929", 39, 29, T1);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 600; i++) tick();
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd1);
    check("mid_rst_ready", 32'(wr_ready), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check("mid_rst_rgb", 32'(rgb), 32'(BLACK));
    rst_n = 1'b1;
    sweep("rst_restart", 0);
    rd_check("post_cell22", 2, 2, BLACK);
    rd_check("post_cell3929", 39, 29, BLACK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mapa_store.md
MAPA_STORE -- requirements
Module: mapa_store

Interface
REQ-001 The parameter SCREEN_WIDTH SHALL default to 640 and gives the visible width in pixels.
REQ-002 The parameter SCREEN_HEIGHT SHALL default to 480 and gives the visible height in pixels.
REQ-003 The parameter BLOCK_BITS SHALL default to 4 and gives log2 of the block size.
REQ-004 The parameter BLOCK_SIZE SHALL default to 16 and gives the block edge in pixels.
REQ-005 The design SHALL use one clock and an asynchronous, active-low reset.
REQ-006 Port clk SHALL be an input, 1 bit wide: the single system clock, rising-edge.
REQ-007 Port rst_n SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-008 Port mapa_read SHALL be an input, 1 bit wide: the renderer requests a cell lookup.
REQ-009 Ports mapa_x and mapa_y SHALL be inputs, 10 bits each: the block column and block row being read.
REQ-010 Ports mapa_R, mapa_G and mapa_B SHALL be outputs, 2 bits each: the registered cell colour sent to the renderer.
REQ-011 Port wr_en SHALL be an input, 1 bit wide: the game logic requests a cell write.
REQ-012 Ports wr_x and wr_y SHALL be inputs, 10 bits each: the block column and block row to write.
REQ-013 Port wr_tipo SHALL be an input, 2 bits wide: the cell type to store.
REQ-014 Port wr_ready SHALL be an output, 1 bit wide: a write is accepted this cycle.
REQ-015 Port clear_req SHALL be an input, 1 bit wide: request to clear the whole map.
REQ-016 Port busy SHALL be an output, 1 bit wide: a clear sweep is in progress.

Function
REQ-017 The grid SHALL be COLS = SCREEN_WIDTH/BLOCK_SIZE (40) by ROWS = SCREEN_HEIGHT/BLOCK_SIZE (30), giving CELLS = 1200 cells of 2-bit type.
REQ-018 The cell address SHALL be y*COLS + x, 11 bits wide, computed without truncation.
REQ-019 The fixed palette SHALL map type 0 to R/G/B 00/00/00, type 1 to 01/01/11, type 2 to 00/11/00, and type 3 to 11/11/11.
REQ-020 The FSM SHALL have exactly two states, CLEAR and IDLE.
REQ-021 In CLEAR, each rising edge SHALL write type 0 to the cell at sweep counter sc, then increment sc.
REQ-022 The edge that writes cell CELLS-1 SHALL move the FSM to IDLE and reset sc to 0.
REQ-023 In IDLE, clear_req=1 SHALL move the FSM to CLEAR with sc=0 on the next edge.
REQ-024 In CLEAR, clear_req SHALL be ignored and the sweep SHALL neither restart nor extend.
REQ-025 busy SHALL equal (state==CLEAR), and wr_ready SHALL equal (state==IDLE), both decoded from registered state.
REQ-026 A write SHALL be accepted when wr_en & wr_ready & !clear_req, and the cell SHALL update at that edge.
REQ-027 clear_req SHALL have priority over a simultaneous wr_en, and the write SHALL be dropped.
REQ-028 A write with wr_x>=COLS or wr_y>=ROWS SHALL be ignored with no aliasing.
REQ-029 Read latency SHALL be 1 cycle: an edge sampling mapa_read=1 SHALL load the palette colour of cell (mapa_x, mapa_y) into mapa_R/G/B.
REQ-030 An edge sampling mapa_read=0 SHALL load 00/00/00, so the outputs are black during blanking.
REQ-031 A read with mapa_x>=COLS or mapa_y>=ROWS SHALL load 00/00/00.
REQ-032 Any read while in CLEAR SHALL load 00/00/00.
REQ-033 A read and a write to the same cell on the same edge SHALL return the old value (read-before-write).
REQ-034 The cell storage SHALL be inferable as a single synchronous RAM with one write port and one read port.
REQ-035 The sweep write and a game write SHALL never occur on the same edge.

Reset
REQ-036 While rst_n=0, the design SHALL hold state=CLEAR, sc=0 and mapa_R/G/B=00/00/00.
REQ-037 While rst_n=0, busy SHALL be 1 and wr_ready SHALL be 0.
REQ-038 RAM contents SHALL not be reset directly; the post-reset sweep SHALL clear them.
REQ-039 After rst_n rises, the first edge SHALL clear cell 0, and busy SHALL fall after the 1200th edge.
REQ-040 A reset asserted mid-sweep or mid-write SHALL abort the operation and restart the sweep from cell 0 after release.

Verification
REQ-041 The bench SHALL check: release reset, hold mapa_read=1 at (0,0) -> busy=1 and output 00/00/00 for 1200 edges; after that, busy=0, wr_ready=1, output 00/00/00.
REQ-042 The bench SHALL check: in IDLE, write tipo=1 at (39,29), then read (39,29) -> mapa_R/G/B=01/01/11 exactly 1 cycle after the read edge.
REQ-043 The bench SHALL check: write tipo=3 at (40,0), then read (0,1) and (40,0) -> both reads return 00/00/00 and no cell changes.
REQ-044 The bench SHALL check: on the same edge, write tipo=2 at (5,5) and read (5,5) -> old value 00/00/00; the next read of (5,5) -> 00/11/00.
REQ-045 The bench SHALL check: on the same IDLE edge, clear_req=1 and wr_en=1 with tipo=3 at (1,1) -> busy=1 on the next cycle; after 1200 edges, read of (1,1) -> 00/00/00 and previously written cells -> 00/00/00.
REQ-046 The bench SHALL check: assert rst_n=0 at sweep cell 600 for 3 cycles, then release -> sc restarts at 0 and busy stays 1 for a full 1200 edges.
